servant_rr_arbiter: RTL and testbench
=====================================

SERVANT_RR_ARBITER -- requirements
Module: servant_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter, listed below.
  TIMEOUT, 8'd255, max downstream cycles per transaction before error-ack; 0 disables timeout
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The ports SHALL be as listed below.
  clk            in   1   clock, all state on rising edge
  rst_n          in   1   synchronous active-low reset
  i_ibus_adr     in   32  instruction master address
  i_ibus_cyc     in   1   instruction master request
  o_ibus_rdt     out  32  instruction read data
  o_ibus_ack     out  1   instruction ack
  i_dbus_adr     in   32  data master address
  i_dbus_dat     in   32  data master write data
  i_dbus_sel     in   4   data master byte select
  i_dbus_we      in   1   data master write enable
  i_dbus_cyc     in   1   data master request
  o_dbus_rdt     out  32  data read data
  o_dbus_ack     out  1   data ack
  o_wb_adr       out  32  shared slave address
  o_wb_dat       out  32  shared slave write data
  o_wb_sel       out  4   shared slave byte select
  o_wb_we        out  1   shared slave write enable
  o_wb_cyc       out  1   shared slave cycle
  i_wb_rdt       in   32  slave read data
  i_wb_ack       in   1   slave ack, single-cycle pulse
  o_grant        out  2   01 = ibus owns bus, 10 = dbus owns bus, 00 = idle
  o_timeout      out  1   one-cycle pulse on timeout error-ack

Function
REQ-004 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-005 In IDLE, any master cyc SHALL register a grant; the FSM enters BUSY next edge, so there is 1 cycle of arbitration latency.
REQ-006 Round-robin rule: if both masters request in IDLE, the master not granted last SHALL win; the last-grant pointer updates when BUSY exits.
REQ-007 o_wb_cyc SHALL be 1 only in BUSY while the granted master's cyc=1 and the timeout has not fired; it SHALL be 0 in IDLE.
REQ-008 When ibus is granted, the slave outputs SHALL be: adr = i_ibus_adr, we = 0, sel = 4'hF, dat = 0.
REQ-009 When dbus is granted, the slave outputs SHALL pass the dbus adr/dat/sel/we through unchanged.
REQ-010 In IDLE, o_wb_adr/dat/sel/we SHALL be 0.
REQ-011 i_wb_ack in BUSY SHALL drive the granted master's ack in the same cycle, combinationally; that master's rdt = i_wb_rdt, and the FSM returns to IDLE next edge.
REQ-012 The non-granted master's ack and rdt SHALL be 0 at all times.
REQ-013 i_wb_ack in IDLE SHALL be ignored: no master ack, no state change.
REQ-014 Timeout counter: 8 bits, cleared on BUSY entry, incremented each BUSY cycle without ack, saturating.
  - If TIMEOUT != 0 and count == TIMEOUT, then in that same cycle: o_wb_cyc = 0, granted master ack = 1 with rdt = 32'h0, o_timeout = 1.
  - The FSM then goes to IDLE and the pointer updates.
REQ-015 i_wb_ack arriving in the timeout cycle SHALL be ignored, because o_wb_cyc = 0 in that cycle.
REQ-016 Abort: if the granted master drops cyc in BUSY, o_wb_cyc SHALL go to 0 in the same cycle, no ack is given, IDLE follows next edge, and the pointer updates.
REQ-017 A master keeping cyc=1 after its ack SHALL be treated as a new request in IDLE; it is subject to round-robin.
REQ-018 o_grant SHALL equal the registered grant in BUSY and 00 in IDLE.

Reset
REQ-019 On a clk edge with rst_n=0, the block SHALL set: state = IDLE, grant = 00, last-grant = dbus (ibus wins the first tie), counter = 0.
REQ-020 All outputs SHALL be 0 during reset and in the first cycle after reset.
REQ-021 Reset mid-BUSY SHALL drop o_wb_cyc the cycle after the reset edge; no ack is forwarded for the aborted transaction.

Verification
REQ-022 The bench SHALL cover the following scenarios.
  - ibus fetch: i_ibus_cyc=1, adr 0x100 at cycle 0; slave acks at cycle 3 with rdt 0x00000013.
    -> o_wb_cyc=1 cycles 1-3, o_wb_adr 0x100, we 0, sel F.
    -> o_ibus_ack=1 and o_ibus_rdt 0x13 at cycle 3; o_grant 01 cycles 1-3.
  - Tie after reset: both cyc=1 continuously.
    -> grant sequence ibus, dbus, ibus, dbus.
    -> each grant separated by exactly 1 IDLE cycle.
  - dbus write: adr 0x4000_0000, dat 0x3, sel 0x1, we 1.
    -> o_wb_we 1, o_wb_dat 0x3, o_wb_sel 0x1; o_dbus_ack mirrors i_wb_ack; o_ibus_ack stays 0.
  - Timeout with TIMEOUT=4 and no slave ack.
    -> o_wb_cyc high 4 cycles, then 1 cycle with o_dbus_ack=1, rdt 0, o_timeout=1.
    -> next request is accepted normally.
  - Abort and stray ack:
    -> dbus drops cyc in BUSY: o_wb_cyc 0 the same cycle, no ack.
    -> i_wb_ack pulsed in IDLE: no ack on either master.
  - Reset at the 2nd BUSY cycle of an ibus fetch.
    -> o_wb_cyc 0, o_grant 00 after the reset edge.
    -> after release, a tie grants ibus first.

Source files
------------

// File: rtl/servant_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one Wishbone slave between the SERV ibus and dbus masters.
// Latency : 1 cycle of arbitration (IDLE) before the slave cycle; acks are forwarded combinationally.
// Backpress: a master waits in cyc until it is granted; a stalled slave is cut off after TIMEOUT cycles with an error-ack.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   i_ibus_*, o_ibus_*  instruction master (read-only): adr/cyc in, rdt/ack out
//   i_dbus_*, o_dbus_*  data master: adr/dat/sel/we/cyc in, rdt/ack out
//   o_wb_*, i_wb_*      shared slave port: adr/dat/sel/we/cyc out, rdt/ack in
//   o_grant             01 = ibus owns the bus, 10 = dbus owns the bus, 00 = idle
//   o_timeout           one-cycle pulse when a transaction is closed by the timeout
module servant_rr_arbiter #(
    // Max BUSY cycles without a slave ack before the error-ack; 0 disables the timeout.
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,

    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,

    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant, grant_nxt;          // one-hot: [0] ibus, [1] dbus
    logic        last_dbus, last_dbus_nxt;  // 1 = dbus held the most recent grant
    logic [7:0]  cnt, cnt_nxt;              // BUSY cycles without ack, saturating

    logic        busy;
    logic        master_cyc;                // granted master still requesting
    logic        timeout_hit;
    logic        live;                      // slave cycle actually presented
    logic        xfer_done;                 // slave ack accepted
    logic        tmo_ack;                   // error-ack generated by the timeout
    logic        abort;

    // ------------------------------------------------------------------
    // Transaction status decode
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state == BUSY);
        master_cyc  = (grant[0] & i_ibus_cyc) | (grant[1] & i_dbus_cyc);
        timeout_hit = busy && (TIMEOUT != 8'd0) && (cnt == TIMEOUT);
        // Abort wins over the timeout: a master that has gone away gets no ack.
        abort       = busy && !master_cyc;
        tmo_ack     = busy && master_cyc && timeout_hit;
        live        = busy && master_cyc && !timeout_hit;
        // A slave ack landing in the timeout cycle is ignored since cyc is already low.
        xfer_done   = live && i_wb_ack;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last_dbus <= 1'b1;      // ibus wins the first tie
            cnt       <= 8'd0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last_dbus <= last_dbus_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_dbus_nxt = last_dbus;
        cnt_nxt       = cnt;

        case (state)
            IDLE: begin
                if (i_ibus_cyc || i_dbus_cyc) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 8'd0;
                    if (i_ibus_cyc && i_dbus_cyc) begin
                        // Tie: the master that was not granted last goes first.
                        grant_nxt = last_dbus ? 2'b01 : 2'b10;
                    end else if (i_ibus_cyc) begin
                        grant_nxt = 2'b01;
                    end else begin
                        grant_nxt = 2'b10;
                    end
                end
            end

            BUSY: begin
                if (abort || tmo_ack || xfer_done) begin
                    // The round-robin pointer only moves once the bus is released.
                    state_nxt     = IDLE;
                    last_dbus_nxt = grant[1];
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux. Everything is forced low while rst_n is asserted so a
    // transaction caught by reset never forwards an ack.
    // ------------------------------------------------------------------
    always_comb begin
        o_wb_adr   = 32'h0;
        o_wb_dat   = 32'h0;
        o_wb_sel   = 4'h0;
        o_wb_we    = 1'b0;
        o_wb_cyc   = 1'b0;
        o_ibus_ack = 1'b0;
        o_ibus_rdt = 32'h0;
        o_dbus_ack = 1'b0;
        o_dbus_rdt = 32'h0;
        o_grant    = 2'b00;
        o_timeout  = 1'b0;

        if (rst_n && busy) begin
            o_grant  = grant;
            o_wb_cyc = live;
            o_timeout = tmo_ack;

            if (grant[0]) begin
                // Instruction fetches are always full-word reads.
                o_wb_adr   = i_ibus_adr;
                o_wb_sel   = 4'hF;
                o_ibus_ack = xfer_done | tmo_ack;
                o_ibus_rdt = live ? i_wb_rdt : 32'h0;
            end else if (grant[1]) begin
                o_wb_adr   = i_dbus_adr;
                o_wb_dat   = i_dbus_dat;
                o_wb_sel   = i_dbus_sel;
                o_wb_we    = i_dbus_we;
                o_dbus_ack = xfer_done | tmo_ack;
                o_dbus_rdt = live ? i_wb_rdt : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_servant_rr_arbiter.sv
module tb_servant_rr_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (0 none, 1 ibus, 2 dbus), who owned it last,
    // and how many BUSY cycles have gone by without an ack.
    int m_own = 0, m_last = 2, m_age = 0;
    int n_own, n_last, n_age;

    servant_rr_arbiter #(.TIMEOUT(8'(TO))) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat),
        .o_wb_sel   (wb_sel),
        .o_wb_we    (wb_we),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack),
        .o_grant    (grant),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample outputs at the falling edge and compare every output with the model.
    task automatic sample();
        logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
        logic [3:0]  e_sel;
        logic [1:0]  e_gnt;
        logic        e_we, e_cyc, e_iack, e_dack, e_to, mcyc, fin;
        @(negedge clk);
        e_adr = 0; e_dat = 0; e_irdt = 0; e_drdt = 0; e_sel = 0; e_gnt = 0;
        e_we = 0; e_cyc = 0; e_iack = 0; e_dack = 0; e_to = 0;
        n_own = m_own; n_last = m_last; n_age = m_age;
        if (!rst_n) begin
            n_own = 0; n_last = 2; n_age = 0;
        end else if (m_own == 0) begin
            if (ibus_cyc && dbus_cyc) n_own = (m_last == 2) ? 1 : 2;
            else if (ibus_cyc)        n_own = 1;
            else if (dbus_cyc)        n_own = 2;
            n_age = 0;
        end else begin
            e_gnt = (m_own == 1) ? 2'b01 : 2'b10;
            if (m_own == 1) begin
                e_adr = ibus_adr; e_sel = 4'hF;
            end else begin
                e_adr = dbus_adr; e_dat = dbus_dat; e_sel = dbus_sel; e_we = dbus_we;
            end
            mcyc = (m_own == 1) ? ibus_cyc : dbus_cyc;
            fin = 1'b0;
            if (!mcyc) begin
                fin = 1'b1;
            end else if (TO != 0 && m_age == TO) begin
                fin = 1'b1;
                e_to = 1'b1;
                if (m_own == 1) e_iack = 1'b1; else e_dack = 1'b1;
            end else begin
                e_cyc = 1'b1;
                if (m_own == 1) begin e_irdt = wb_rdt; e_iack = wb_ack; end
                else            begin e_drdt = wb_rdt; e_dack = wb_ack; end
                fin = wb_ack;
            end
            if (fin) begin
                n_own = 0; n_last = m_own;
            end else begin
                n_age = (m_age < 255) ? m_age + 1 : 255;
            end
        end
        chk("m_wb_adr", wb_adr, e_adr);
        chk("m_wb_dat", wb_dat, e_dat);
        chk("m_wb_sel", 32'(wb_sel), 32'(e_sel));
        chk("m_wb_we", 32'(wb_we), 32'(e_we));
        chk("m_wb_cyc", 32'(wb_cyc), 32'(e_cyc));
        chk("m_ibus_ack", 32'(ibus_ack), 32'(e_iack));
        chk("m_ibus_rdt", ibus_rdt, e_irdt);
        chk("m_dbus_ack", 32'(dbus_ack), 32'(e_dack));
        chk("m_dbus_rdt", dbus_rdt, e_drdt);
        chk("m_grant", 32'(grant), 32'(e_gnt));
        chk("m_timeout", 32'(timeout), 32'(e_to));
    endtask

    task automatic advance();
        @(posedge clk);
        m_own = n_own; m_last = n_last; m_age = n_age;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample(); advance();
        sample(); advance();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ibus_adr = 0; ibus_cyc = 0;
        dbus_adr = 0; dbus_dat = 0; dbus_sel = 0; dbus_we = 0; dbus_cyc = 0;
        wb_rdt = 0; wb_ack = 0;

        // Reset and first cycle after reset
        do_reset();
        sample();
        chk("post_reset_cyc", 32'(wb_cyc), 0);
        chk("post_reset_grant", 32'(grant), 0);
        advance();

        // ibus fetch: cyc at cycle 0, slave ack at cycle 3
        ibus_cyc = 1; ibus_adr = 32'h100;
        sample();
        chk("fetch_c0_cyc", 32'(wb_cyc), 0);
        advance();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin wb_ack = 1; wb_rdt = 32'h13; end
            sample();
            chk("fetch_cyc", 32'(wb_cyc), 1);
            chk("fetch_adr", wb_adr, 32'h100);
            chk("fetch_sel", 32'(wb_sel), 32'hF);
            chk("fetch_we", 32'(wb_we), 0);
            chk("fetch_grant", 32'(grant), 32'b01);
            chk("fetch_ack", 32'(ibus_ack), (c == 3) ? 1 : 0);
            if (c == 3) chk("fetch_rdt", ibus_rdt, 32'h13);
            advance();
        end
        ibus_cyc = 0; wb_ack = 0; wb_rdt = 0;
        sample(); advance();

        // Tie after reset: ibus, dbus, ibus, dbus with one IDLE cycle in between
        do_reset();
        ibus_cyc = 1; dbus_cyc = 1; wb_ack = 1;
        for (int c = 0; c < 8; c++) begin
            sample();
            chk("tie_grant", 32'(grant), (c % 2 == 0) ? 0 : (((c / 2) % 2 == 0) ? 32'b01 : 32'b10));
            advance();
        end
        ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0;
        sample(); advance();

        // dbus write
        dbus_cyc = 1; dbus_adr = 32'h4000_0000; dbus_dat = 32'h3; dbus_sel = 4'h1; dbus_we = 1;
        sample(); advance();
        sample();
        chk("wr_we", 32'(wb_we), 1);
        chk("wr_dat", wb_dat, 32'h3);
        chk("wr_sel", 32'(wb_sel), 32'h1);
        chk("wr_adr", wb_adr, 32'h4000_0000);
        chk("wr_dack_wait", 32'(dbus_ack), 0);
        advance();
        wb_ack = 1;
        sample();
        chk("wr_dack", 32'(dbus_ack), 1);
        chk("wr_iack", 32'(ibus_ack), 0);
        advance();
        dbus_cyc = 0; dbus_we = 0; wb_ack = 0;
        sample(); advance();

        // Timeout: no slave ack; an ack in the timeout cycle is ignored
        dbus_cyc = 1; dbus_adr = 32'h2000; dbus_sel = 4'hF;
        sample(); advance();
        for (int c = 1; c <= TO; c++) begin
            sample();
            chk("to_cyc", 32'(wb_cyc), 1);
            chk("to_dack_wait", 32'(dbus_ack), 0);
            chk("to_pulse_wait", 32'(timeout), 0);
            advance();
        end
        wb_ack = 1; wb_rdt = 32'hDEAD_BEEF;
        sample();
        chk("to_cyc_low", 32'(wb_cyc), 0);
        chk("to_dack", 32'(dbus_ack), 1);
        chk("to_drdt", dbus_rdt, 0);
        chk("to_pulse", 32'(timeout), 1);
        advance();
        dbus_cyc = 0; wb_ack = 0; wb_rdt = 0;
        sample();
        chk("to_idle_grant", 32'(grant), 0);
        advance();
        ibus_cyc = 1; ibus_adr = 32'h200;
        sample(); advance();
        wb_ack = 1; wb_rdt = 32'h55;
        sample();
        chk("after_to_cyc", 32'(wb_cyc), 1);
        chk("after_to_iack", 32'(ibus_ack), 1);
        chk("after_to_irdt", ibus_rdt, 32'h55);
        advance();
        ibus_cyc = 0; wb_ack = 0; wb_rdt = 0;
        sample(); advance();

        // Abort by the dbus, then a stray ack in IDLE
        dbus_cyc = 1;
        sample(); advance();
        sample();
        chk("abort_busy_cyc", 32'(wb_cyc), 1);
        advance();
        dbus_cyc = 0; wb_ack = 1; wb_rdt = 32'h77;
        sample();
        chk("abort_cyc", 32'(wb_cyc), 0);
        chk("abort_dack", 32'(dbus_ack), 0);
        chk("abort_iack", 32'(ibus_ack), 0);
        advance();
        sample();
        chk("stray_grant", 32'(grant), 0);
        chk("stray_iack", 32'(ibus_ack), 0);
        chk("stray_dack", 32'(dbus_ack), 0);
        advance();
        wb_ack = 0; wb_rdt = 0;
        sample();
        chk("stray_after_grant", 32'(grant), 0);
        advance();

        // Reset at the second BUSY cycle of an ibus fetch
        ibus_cyc = 1; ibus_adr = 32'h300;
        sample(); advance();
        sample();
        chk("rst_busy1_cyc", 32'(wb_cyc), 1);
        advance();
        rst_n = 0;
        sample(); advance();
        rst_n = 1; dbus_cyc = 1;
        sample();
        chk("rst_after_cyc", 32'(wb_cyc), 0);
        chk("rst_after_grant", 32'(grant), 0);
        advance();
        sample();
        chk("rst_tie_grant", 32'(grant), 32'b01);
        advance();
        ibus_cyc = 0; dbus_cyc = 0;
        sample(); advance();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 9) < 2) ibus_cyc = ~ibus_cyc;
            if ($urandom_range(0, 9) < 2) dbus_cyc = ~dbus_cyc;
            ibus_adr = $urandom;
            dbus_adr = $urandom;
            dbus_dat = $urandom;
            dbus_sel = 4'($urandom_range(0, 15));
            dbus_we  = 1'($urandom_range(0, 1));
            wb_ack   = ($urandom_range(0, 3) == 0);
            wb_rdt   = $urandom;
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
